pwm_phase_gen: RTL and testbench
================================

# pwm_phase_gen

Phase-shifted PWM generator for one channel. It sits directly downstream of the per-channel phase controller FSM and consumes its current phase and its channel-enable. Its PWM output is returned to that FSM as the PWM signal it counts edges on. Duty, period and phase are applied through shadow registers, so a change takes effect only at a period boundary and never produces a runt pulse.

## Interface

Parameters:
- PWM_CNT_WIDTH, default 24: width of the counter, period, duty and phase values.

Ports:
- axi_clk  in  1  single clock; all logic is on its rising edge.
- axi_rstn  in  1  reset, synchronous, active-low.
- pwm_en_i  in  1  channel run request from AXI.
- pwm_period_i  in  PWM_CNT_WIDTH  last counter value; cycle length is pwm_period_i+1 clocks.
- pwm_duty_i  in  PWM_CNT_WIDTH  high time in clocks.
- pwm_phase_i  in  PWM_CNT_WIDTH  static phase from AXI.
- phase_ch_en_i  in  1  phase FSM owns the phase when 1.
- phase_cur_phase_i  in  PWM_CNT_WIDTH  phase from the phase FSM.
- pwm_o  out  1  registered PWM output; also feeds the FSM's pwm_sig_i.
- pwm_cnt_o  out  PWM_CNT_WIDTH  current counter value.
- pwm_period_end_o  out  1  one-cycle pulse, registered, marking the end of each period.
- pwm_active_o  out  1  1 when the state is RUN or DRAIN.

## Operation

States:
- IDLE
  - Counter is held at 0 and pwm_o is 0.
  - If pwm_en_i=1 and pwm_period_i≠0: load the shadow registers, set cnt←0, go to RUN.
  - If pwm_period_i=0: stay in IDLE.
- RUN
  - cnt increments each cycle and wraps from period_s to 0.
  - If pwm_en_i=0: go to DRAIN.
- DRAIN
  - Counter keeps running.
  - At the cycle where cnt==period_s: go to IDLE and set cnt←0.
  - If pwm_en_i returns to 1 before that cycle: go back to RUN with no interruption to the waveform.

Shadow registers: period_s, duty_s and phase_s.
- They load on the IDLE→RUN transition and on every wrap in RUN (cnt==period_s).
- On a wrap, the new values apply from cnt=0 of the next period.

Phase selection:
- Phase source is phase_cur_phase_i when phase_ch_en_i=1, else pwm_phase_i, sampled at shadow load.
- A selected phase greater than the period is clamped to the period.
- Phase changes from the FSM mid-period are ignored until the next wrap.

Output logic:
- Shifted position: pos = cnt−phase_s if cnt≥phase_s, else cnt+period_s+1−phase_s.
- pwm_o ← (state≠IDLE) && (pos < duty_s).
- duty_s=0 gives a constant low output.
- duty_s>period_s gives a constant high output for the whole period.

Arithmetic:
- All comparisons are unsigned.
- The intermediate sum cnt+period_s+1 is computed at PWM_CNT_WIDTH+1 bits, so no overflow is possible.

Period-end pulse: pwm_period_end_o is 1 in the cycle after any cycle where state≠IDLE and cnt==period_s.

## Timing

- Reset (axi_rstn=0 at a clock edge) puts every register in its reset value:
  - state=IDLE, cnt=0, all shadow registers 0.
  - pwm_o=0, pwm_period_end_o=0, pwm_active_o=0.
  - Reset mid-period takes effect at that same edge; there is no drain.
- Start latency:
  - pwm_en_i sampled high at edge N gives cnt=0 and pwm_active_o=1 after edge N.
  - pwm_o then reflects cnt=0 after edge N+1.
  - pwm_o therefore lags pwm_cnt_o by exactly one clock.
- Shadow updates: an update presented at the input in the cycle where cnt==period_s is captured; the waveform changes from the next cnt=0.
- Disable: pwm_active_o drops one cycle after the final cnt==period_s, and pwm_o is 0 from that cycle on.
- Simultaneous events: pwm_en_i falling in the cycle where cnt==period_s still performs the shadow load, then goes to DRAIN, completes one full period, then goes to IDLE.

## Test plan

- **Basic waveform.** period=9, duty=3, phase=0, pwm_en_i=1 → pwm_o high for 3 clocks out of every 10, pwm_period_end_o pulses every 10 clocks, pwm_o lags pwm_cnt_o by 1 clock.
- **Phase shift and wrap.**
  - phase=4, duty=3 → pwm_o high when cnt is 4..6.
  - phase=8, duty=4 → pwm_o high when cnt is 8, 9, 0, 1.
  - phase=15 with period=9 → clamped, behaves as phase=9.
- **FSM ownership.**
  - phase_ch_en_i=1 and phase_cur_phase_i changes 0→5 when cnt=3 → waveform unchanged until the wrap, then high when cnt is 5..7; pwm_phase_i is ignored.
  - phase_ch_en_i drops → the AXI phase is used from the next period.
- **Extremes.**
  - duty=0 → pwm_o is always 0.
  - duty=12 with period=9 → pwm_o is always 1 while active.
  - pwm_period_i=0 with pwm_en_i=1 → stays in IDLE, pwm_active_o=0.
- **Graceful stop.**
  - pwm_en_i drops when cnt=2 → the period completes and pwm_active_o falls one cycle after cnt==9.
  - pwm_en_i re-asserted when cnt=6 in DRAIN → continuous waveform, never IDLE.
- **Reset mid-run.** axi_rstn=0 for 1 cycle when cnt=5 → next cycle shows pwm_o=0, pwm_cnt_o=0, pwm_active_o=0; with pwm_en_i held high it restarts cleanly.

Source files
------------

// File: rtl/pwm_phase_gen.sv
// Phase-shifted single-channel PWM generator. Period, duty and phase pass through
// shadow registers that reload only at a period boundary, so the output never glitches.
module pwm_phase_gen #(
    parameter int PWM_CNT_WIDTH = 24
) (
    input  logic                     axi_clk,
    input  logic                     axi_rstn,
    input  logic                     pwm_en_i,
    input  logic [PWM_CNT_WIDTH-1:0] pwm_period_i,
    input  logic [PWM_CNT_WIDTH-1:0] pwm_duty_i,
    input  logic [PWM_CNT_WIDTH-1:0] pwm_phase_i,
    input  logic                     phase_ch_en_i,
    input  logic [PWM_CNT_WIDTH-1:0] phase_cur_phase_i,
    output logic                     pwm_o,
    output logic [PWM_CNT_WIDTH-1:0] pwm_cnt_o,
    output logic                     pwm_period_end_o,
    output logic                     pwm_active_o
);

    localparam int W = PWM_CNT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   period_s_q, period_s_d;
    logic [W-1:0]   duty_s_q, duty_s_d;
    logic [W-1:0]   phase_s_q, phase_s_d;
    logic           pwm_q, pwm_d;
    logic           period_end_q, period_end_d;

    logic           at_end;
    logic           load_shadow;
    logic [W-1:0]   phase_sel;
    logic [W-1:0]   phase_clamped;
    logic [W:0]     pos;

    assign at_end = (cnt_q == period_s_q);

    always_ff @(posedge axi_clk) begin
        if (!axi_rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_s_q   <= '0;
            duty_s_q     <= '0;
            phase_s_q    <= '0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_s_q   <= period_s_d;
            duty_s_q     <= duty_s_d;
            phase_s_q    <= phase_s_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    // A drain that reaches the period end returns to IDLE even if the run request
    // reappears in that very cycle; the restart then goes through IDLE normally.
    always_comb begin
        state_d     = state_q;
        load_shadow = 1'b0;
        case (state_q)
            IDLE: begin
                if (pwm_en_i && (pwm_period_i != '0)) begin
                    state_d     = RUN;
                    load_shadow = 1'b1;
                end
            end
            RUN: begin
                if (at_end) begin
                    load_shadow = 1'b1;
                end
                if (!pwm_en_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (at_end) begin
                    state_d = IDLE;
                end else if (pwm_en_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        phase_sel     = phase_ch_en_i ? phase_cur_phase_i : pwm_phase_i;
        phase_clamped = (phase_sel > pwm_period_i) ? pwm_period_i : phase_sel;

        if (cnt_q >= phase_s_q) begin
            pos = {1'b0, cnt_q} - {1'b0, phase_s_q};
        end else begin
            pos = {1'b0, cnt_q} + {1'b0, period_s_q} + {{W{1'b0}}, 1'b1} - {1'b0, phase_s_q};
        end

        cnt_d        = ((state_q == IDLE) || at_end) ? '0 : cnt_q + 1'b1;
        period_s_d   = load_shadow ? pwm_period_i  : period_s_q;
        duty_s_d     = load_shadow ? pwm_duty_i    : duty_s_q;
        phase_s_d    = load_shadow ? phase_clamped : phase_s_q;

        // Gating on the next state too keeps the output low from the very cycle
        // the channel drops back to IDLE.
        pwm_d        = (state_q != IDLE) && (state_d != IDLE) && (pos < {1'b0, duty_s_q});
        period_end_d = (state_q != IDLE) && at_end;
    end

    assign pwm_o            = pwm_q;
    assign pwm_cnt_o        = cnt_q;
    assign pwm_period_end_o = period_end_q;
    assign pwm_active_o     = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Directed bench for pwm_phase_gen: a vector table for reset/start/basic waveform,
// then hand-written sequences for phase, ownership, extremes, drain and reset.
module tb_pwm_phase_gen;

    logic        axi_clk;
    logic        axi_rstn;
    logic        pwm_en_i;
    logic [23:0] pwm_period_i;
    logic [23:0] pwm_duty_i;
    logic [23:0] pwm_phase_i;
    logic        phase_ch_en_i;
    logic [23:0] phase_cur_phase_i;
    logic        pwm_o;
    logic [23:0] pwm_cnt_o;
    logic        pwm_period_end_o;
    logic        pwm_active_o;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        rstn;
        logic        en;
        logic [23:0] period;
        logic [23:0] duty;
        logic [23:0] phase;
        logic        exp_pwm;
        logic [23:0] exp_cnt;
        logic        exp_pend;
        logic        exp_act;
    } vec_t;

    vec_t vecs[$];

    // Masks are indexed by counter value; bit n set means pwm_o high for cnt=n.
    localparam logic [9:0] M_PH0  = 10'b0000000111;
    localparam logic [9:0] M_PH4  = 10'b0001110000;
    localparam logic [9:0] M_PH8  = 10'b1100000011;
    localparam logic [9:0] M_PH9  = 10'b1000000011;
    localparam logic [9:0] M_PH5  = 10'b0011100000;
    localparam logic [9:0] M_PH7  = 10'b1110000000;
    localparam logic [9:0] M_NONE = 10'b0000000000;
    localparam logic [9:0] M_ALL  = 10'b1111111111;

    pwm_phase_gen #(.PWM_CNT_WIDTH(24)) dut (
        .axi_clk           (axi_clk),
        .axi_rstn          (axi_rstn),
        .pwm_en_i          (pwm_en_i),
        .pwm_period_i      (pwm_period_i),
        .pwm_duty_i        (pwm_duty_i),
        .pwm_phase_i       (pwm_phase_i),
        .phase_ch_en_i     (phase_ch_en_i),
        .phase_cur_phase_i (phase_cur_phase_i),
        .pwm_o             (pwm_o),
        .pwm_cnt_o         (pwm_cnt_o),
        .pwm_period_end_o  (pwm_period_end_o),
        .pwm_active_o      (pwm_active_o)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    function automatic vec_t mkVec(input logic rstn, input logic en, input int period,
                                   input int duty, input int phase, input logic e_pwm,
                                   input int e_cnt, input logic e_pend, input logic e_act);
        vec_t v;
        v.rstn     = rstn;
        v.en       = en;
        v.period   = 24'(period);
        v.duty     = 24'(duty);
        v.phase    = 24'(phase);
        v.exp_pwm  = e_pwm;
        v.exp_cnt  = 24'(e_cnt);
        v.exp_pend = e_pend;
        v.exp_act  = e_act;
        return v;
    endfunction

    task automatic applyStimulus(input logic rstn, input logic en, input int period,
                                 input int duty, input int phase, input logic ch_en,
                                 input int cur_phase);
        axi_rstn          = rstn;
        pwm_en_i          = en;
        pwm_period_i      = 24'(period);
        pwm_duty_i        = 24'(duty);
        pwm_phase_i       = 24'(phase);
        phase_ch_en_i     = ch_en;
        phase_cur_phase_i = 24'(cur_phase);
    endtask

    task automatic stepClock();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_pwm, input int e_cnt,
                               input logic e_pend, input logic e_act);
        tests_run++;
        if (pwm_o !== e_pwm || pwm_cnt_o !== 24'(e_cnt) ||
            pwm_period_end_o !== e_pend || pwm_active_o !== e_act) begin
            tests_failed++;
            $display("[TB] FAIL %s: got pwm=%0b cnt=%0d pend=%0b act=%0b, expected pwm=%0b cnt=%0d pend=%0b act=%0b",
                     name, pwm_o, pwm_cnt_o, pwm_period_end_o, pwm_active_o,
                     e_pwm, e_cnt, e_pend, e_act);
        end
    endtask

    // Period is 9 in every hand sequence, so the counter cycles through 0..9.
    task automatic checkCycles(input string name, input int c0, input int n,
                               input logic [9:0] mask);
        int pc;
        int ec;
        for (int i = 1; i <= n; i++) begin
            stepClock();
            pc = (c0 + i - 1) % 10;
            ec = (c0 + i) % 10;
            checkOutput(name, mask[pc], ec, (pc == 9), 1'b1);
        end
    endtask

    task automatic runToCnt(input string name, input int target);
        int budget;
        budget = 0;
        stepClock();
        while (pwm_cnt_o !== 24'(target) && budget < 40) begin
            stepClock();
            budget++;
        end
        if (pwm_cnt_o !== 24'(target)) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: counter never reached %0d, got %0d", name, target, pwm_cnt_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);

        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 1, 2, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 1, 3, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 4, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 5, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 6, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 7, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 8, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 9, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 0, 1, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 1, 2, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 1, 3, 0, 1));
        vecs.push_back(mkVec(1, 1, 9, 3, 0, 0, 4, 0, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstn, vecs[i].en, int'(vecs[i].period),
                          int'(vecs[i].duty), int'(vecs[i].phase), 1'b0, 0);
            stepClock();
            checkOutput($sformatf("table[%0d]", i), vecs[i].exp_pwm, int'(vecs[i].exp_cnt),
                        vecs[i].exp_pend, vecs[i].exp_act);
        end

        applyStimulus(1, 1, 9, 3, 4, 0, 0);
        runToCnt("phase4_sync", 0);
        checkCycles("phase4", 0, 10, M_PH4);

        applyStimulus(1, 1, 9, 4, 8, 0, 0);
        runToCnt("phase8_sync", 0);
        checkCycles("phase8_wrap", 0, 10, M_PH8);

        applyStimulus(1, 1, 9, 3, 15, 0, 0);
        runToCnt("clamp_sync", 0);
        checkCycles("phase_clamp", 0, 10, M_PH9);

        applyStimulus(1, 1, 9, 0, 0, 0, 0);
        runToCnt("duty0_sync", 0);
        checkCycles("duty0", 0, 10, M_NONE);

        applyStimulus(1, 1, 9, 12, 0, 0, 0);
        runToCnt("duty12_sync", 0);
        checkCycles("duty_over_period", 0, 10, M_ALL);

        applyStimulus(1, 1, 9, 3, 7, 1, 0);
        runToCnt("fsm_sync", 0);
        checkCycles("fsm_phase0", 0, 3, M_PH0);
        applyStimulus(1, 1, 9, 3, 7, 1, 5);
        checkCycles("fsm_midperiod_ignored", 3, 7, M_PH0);
        checkCycles("fsm_phase5", 0, 10, M_PH5);
        applyStimulus(1, 1, 9, 3, 7, 0, 5);
        checkCycles("fsm_release_pending", 0, 10, M_PH5);
        checkCycles("axi_phase7", 0, 10, M_PH7);

        applyStimulus(1, 1, 9, 3, 0, 0, 0);
        runToCnt("stop_sync", 0);
        runToCnt("stop_at2", 2);
        applyStimulus(1, 0, 9, 3, 0, 0, 0);
        checkCycles("drain", 2, 7, M_PH0);
        stepClock();
        checkOutput("drain_end", 1'b0, 0, 1'b1, 1'b0);
        stepClock();
        checkOutput("idle_after_drain", 1'b0, 0, 1'b0, 1'b0);

        applyStimulus(1, 1, 9, 3, 0, 0, 0);
        stepClock();
        checkOutput("restart", 1'b0, 0, 1'b0, 1'b1);
        runToCnt("reassert_at2", 2);
        applyStimulus(1, 0, 9, 3, 0, 0, 0);
        runToCnt("reassert_at6", 6);
        applyStimulus(1, 1, 9, 3, 0, 0, 0);
        checkCycles("drain_reassert", 6, 14, M_PH0);

        runToCnt("reset_at5", 5);
        applyStimulus(0, 1, 9, 3, 0, 0, 0);
        stepClock();
        checkOutput("reset_midrun", 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1, 1, 9, 3, 0, 0, 0);
        stepClock();
        checkOutput("reset_restart", 1'b0, 0, 1'b0, 1'b1);
        checkCycles("after_reset", 0, 10, M_PH0);

        runToCnt("simul_at9", 9);
        applyStimulus(1, 0, 9, 3, 4, 0, 0);
        checkCycles("simul_last_old", 9, 1, M_PH0);
        checkCycles("simul_drain_new", 0, 9, M_PH4);
        stepClock();
        checkOutput("simul_idle", 1'b0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
